// File: rtl/display_mode_scheduler.sv
// display_mode_scheduler
//   Frame-synchronous output selector for the volume-bar, waveform and
//   arcade-game subsystems sharing the OLED, LEDs and 7-segment display.
//   A mode request (sw[15:13], priority game > wave > volume) must stay
//   stable for STABLE_FRAMES frame pulses. The outputs are then blanked for
//   BLANK_FRAMES whole frames. The new mode is committed on a frame boundary.
//
//   Ports
//     clk, reset            6.25 MHz clock, synchronous active-high reset
//     mode_req[2:0]         [2]=volume [1]=waveform [0]=game
//     freeze                holds the waveform mode while it is shown
//     frame_begin           one-cycle pulse at the start of each OLED frame
//     pixel_index[12:0]     current pixel (used only with MODE_TAG_EN)
//     oled_*, led_*, an_*, seg_*   subsystem sources
//     oled_data, led, an, seg      registered outputs to the pins
//     cur_mode[1:0]         0=OFF 1=VOL 2=WAVE 3=GAME
//     switching             high while a mode change is pending or blanking
//
//   Optional: define MODE_TAG_EN to overlay a 4x4 mode-colour tag in the
//   top-right corner of the panel while showing.
module display_mode_scheduler #(
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned BLANK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mode_req,
  input  logic        freeze,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  input  logic [15:0] oled_volume,
  input  logic [15:0] oled_wave,
  input  logic [15:0] oled_game,
  input  logic [15:0] led_mic,
  input  logic [15:0] led_game,
  input  logic [3:0]  an_mic,
  input  logic [3:0]  an_game,
  input  logic [7:0]  seg_mic,
  input  logic [7:0]  seg_game,
  output logic [15:0] oled_data,
  output logic [15:0] led,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic [1:0]  cur_mode,
  output logic        switching
);

  typedef enum logic [1:0] {MODE_OFF = 2'd0, MODE_VOL = 2'd1, MODE_WAVE = 2'd2, MODE_GAME = 2'd3} mode_e;
  typedef enum logic [1:0] {ST_SHOW = 2'd0, ST_PEND = 2'd1, ST_BLANK = 2'd2} state_e;

  localparam logic [3:0] STAB_LAST  = 4'(STABLE_FRAMES - 1);
  localparam logic [3:0] BLANK_LAST = 4'(BLANK_FRAMES - 1);

  state_e      state_q, state_d;
  mode_e       cur_q, cur_d, tgt_q, tgt_d, req_mode;
  logic [3:0]  stab_q, stab_d, blank_q, blank_d;
  logic [15:0] oled_q, oled_d, led_q, led_d;
  logic [3:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic        sw_q;

  always_comb begin
    if (mode_req[0])      req_mode = MODE_GAME;
    else if (mode_req[1]) req_mode = MODE_WAVE;
    else if (mode_req[2]) req_mode = MODE_VOL;
    else                  req_mode = MODE_OFF;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    stab_d  = stab_q;
    blank_d = blank_q;
    unique case (state_q)
      ST_SHOW: begin
        if (req_mode != cur_q && !(freeze && cur_q == MODE_WAVE)) begin
          tgt_d   = req_mode;
          stab_d  = '0;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (req_mode == cur_q) begin
          state_d = ST_SHOW;
        end else if (req_mode != tgt_q) begin
          tgt_d  = req_mode;
          stab_d = '0;
        end else if (frame_begin) begin
          if (stab_q == STAB_LAST) begin
            blank_d = '0;
            state_d = ST_BLANK;
          end else if (stab_q != '1) begin
            stab_d = stab_q + 4'd1;
          end
        end
      end
      ST_BLANK: begin
        if (frame_begin) begin
          if (req_mode != tgt_q) begin
            tgt_d   = req_mode;
            blank_d = '0;
          end else if (blank_q == BLANK_LAST) begin
            cur_d   = tgt_q;
            state_d = ST_SHOW;
          end else if (blank_q != '1) begin
            blank_d = blank_q + 4'd1;
          end
        end
      end
      default: state_d = ST_SHOW;
    endcase
  end

`ifdef MODE_TAG_EN
  logic tag_hit;
  always_comb begin
    tag_hit = (pixel_index < 13'd384) && ((pixel_index % 13'd96) >= 13'd92);
  end
`else
  logic unused_pix;
  assign unused_pix = ^pixel_index;
`endif

  // Routing follows the next-state values, so the pixel sampled on the
  // committing frame_begin already comes from the new source and the one
  // sampled on the frame_begin entering BLANK is already black.
  always_comb begin
    oled_d = '0;
    led_d  = '0;
    an_d   = '1;
    seg_d  = '1;
    if (state_d != ST_BLANK) begin
      unique case (cur_d)
        MODE_OFF:  begin oled_d = '0;          led_d = led_mic;  an_d = an_mic;  seg_d = seg_mic;  end
        MODE_VOL:  begin oled_d = oled_volume; led_d = led_mic;  an_d = an_mic;  seg_d = seg_mic;  end
        MODE_WAVE: begin oled_d = oled_wave;   led_d = led_mic;  an_d = an_mic;  seg_d = seg_mic;  end
        default:   begin oled_d = oled_game;   led_d = led_game; an_d = an_game; seg_d = seg_game; end
      endcase
`ifdef MODE_TAG_EN
      if (state_d == ST_SHOW && tag_hit) begin
        unique case (cur_d)
          MODE_VOL:  oled_d = 16'h07E0;
          MODE_WAVE: oled_d = 16'h001F;
          MODE_GAME: oled_d = 16'hF800;
          default:   ;
        endcase
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SHOW;
      cur_q   <= MODE_OFF;
      tgt_q   <= MODE_OFF;
      stab_q  <= '0;
      blank_q <= '0;
      oled_q  <= '0;
      led_q   <= '0;
      an_q    <= '1;
      seg_q   <= '1;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      stab_q  <= stab_d;
      blank_q <= blank_d;
      oled_q  <= oled_d;
      led_q   <= led_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      sw_q    <= (state_d != ST_SHOW);
    end
  end

  assign oled_data = oled_q;
  assign led       = led_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign cur_mode  = cur_q;
  assign switching = sw_q;

endmodule

// File: tb/tb_display_mode_scheduler.sv
module tb_display_mode_scheduler;

  localparam int STABLE = 3;
  localparam int BLANK  = 2;

  localparam logic [15:0] OV = 16'h1111, OW = 16'h2222, OG = 16'h3333;
  localparam logic [15:0] LM = 16'hAAAA, LG = 16'h5555;
  localparam logic [3:0]  AM = 4'hE, AG = 4'hD;
  localparam logic [7:0]  SM = 8'hC0, SG = 8'hF9;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mode_req;
  logic        freeze;
  logic        frame_begin;
  logic [12:0] pixel_index;
  logic [15:0] oled_volume, oled_wave, oled_game, led_mic, led_game;
  logic [3:0]  an_mic, an_game;
  logic [7:0]  seg_mic, seg_game;
  logic [15:0] oled_data, led;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  cur_mode;
  logic        switching;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  display_mode_scheduler #(.STABLE_FRAMES(STABLE), .BLANK_FRAMES(BLANK)) dut (
    .clk(clk), .reset(reset), .mode_req(mode_req), .freeze(freeze),
    .frame_begin(frame_begin), .pixel_index(pixel_index),
    .oled_volume(oled_volume), .oled_wave(oled_wave), .oled_game(oled_game),
    .led_mic(led_mic), .led_game(led_game), .an_mic(an_mic), .an_game(an_game),
    .seg_mic(seg_mic), .seg_game(seg_game),
    .oled_data(oled_data), .led(led), .an(an), .seg(seg),
    .cur_mode(cur_mode), .switching(switching)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_cur, input logic e_sw,
                           input logic [15:0] e_oled, input logic [15:0] e_led,
                           input logic [3:0] e_an, input logic [7:0] e_seg);
    chk({tag, ".cur_mode"},  16'(cur_mode),  16'(e_cur));
    chk({tag, ".switching"}, 16'(switching), 16'(e_sw));
    chk({tag, ".oled_data"}, oled_data,      e_oled);
    chk({tag, ".led"},       led,            e_led);
    chk({tag, ".an"},        16'(an),        16'(e_an));
    chk({tag, ".seg"},       16'(seg),       16'(e_seg));
  endtask

  // Expected pins for the fixed directed-test source values.
  task automatic expect_mode(input string tag, input logic [1:0] m, input logic sw, input logic blank);
    if (blank) check_all(tag, m, sw, 16'h0, 16'h0, 4'hF, 8'hFF);
    else case (m)
      2'd0: check_all(tag, m, sw, 16'h0, LM, AM, SM);
      2'd1: check_all(tag, m, sw, OV,    LM, AM, SM);
      2'd2: check_all(tag, m, sw, OW,    LM, AM, SM);
      default: check_all(tag, m, sw, OG, LG, AG, SG);
    endcase
  endtask

  task automatic cyc(input logic [2:0] req, input logic frz, input logic fb);
    mode_req    = req;
    freeze      = frz;
    frame_begin = fb;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] req;
    logic       frz;
    logic       fb;
    logic [1:0] cur;
    logic       sw;
    logic       blank;
  } vec_t;

  vec_t tbl[22];

  // ---------------- reference model (frame-counting view) ----------------
  int          m_phase;  // 0 showing, 1 waiting for stability, 2 dark
  int          m_frames; // frame pulses counted in the current phase
  logic [1:0]  m_cur, m_tgt;

  function automatic logic [1:0] wanted(input logic [2:0] r);
    if (r[0]) return 2'd3;
    if (r[1]) return 2'd2;
    if (r[2]) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_cycle_and_check();
    logic [1:0]  rq;
    logic [15:0] e_oled, e_led;
    logic [3:0]  e_an;
    logic [7:0]  e_seg;
    if (reset) begin
      m_phase = 0; m_frames = 0; m_cur = 2'd0; m_tgt = 2'd0;
      check_all("rand_rst", 2'd0, 1'b0, 16'h0, 16'h0, 4'hF, 8'hFF);
      return;
    end
    rq = wanted(mode_req);
    if (m_phase == 0) begin
      if (rq != m_cur && !(freeze && m_cur == 2'd2)) begin
        m_tgt = rq; m_frames = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (rq == m_cur) m_phase = 0;
      else if (rq != m_tgt) begin m_tgt = rq; m_frames = 0; end
      else if (frame_begin) begin
        m_frames++;
        if (m_frames == STABLE) begin m_phase = 2; m_frames = 0; end
      end
    end else if (frame_begin) begin
      if (rq != m_tgt) begin m_tgt = rq; m_frames = 0; end
      else begin
        m_frames++;
        if (m_frames == BLANK) begin m_cur = m_tgt; m_phase = 0; end
      end
    end
    if (m_phase == 2) begin
      e_oled = 16'h0; e_led = 16'h0; e_an = 4'hF; e_seg = 8'hFF;
    end else begin
      e_led = (m_cur == 2'd3) ? led_game : led_mic;
      e_an  = (m_cur == 2'd3) ? an_game  : an_mic;
      e_seg = (m_cur == 2'd3) ? seg_game : seg_mic;
      case (m_cur)
        2'd0: e_oled = 16'h0;
        2'd1: e_oled = oled_volume;
        2'd2: e_oled = oled_wave;
        default: e_oled = oled_game;
      endcase
`ifdef MODE_TAG_EN
      if (m_phase == 0 && (int'(pixel_index) % 96) >= 92 && (int'(pixel_index) / 96) <= 3)
        case (m_cur)
          2'd1: e_oled = 16'h07E0;
          2'd2: e_oled = 16'h001F;
          2'd3: e_oled = 16'hF800;
          default: ;
        endcase
`endif
    end
    check_all("rand", m_cur, (m_phase != 0), e_oled, e_led, e_an, e_seg);
  endtask

  initial begin
    reset = 1'b1; mode_req = 3'b100; freeze = 1'b0; frame_begin = 1'b0; pixel_index = '0;
    oled_volume = OV; oled_wave = OW; oled_game = OG;
    led_mic = LM; led_game = LG; an_mic = AM; an_game = AG; seg_mic = SM; seg_game = SG;

    tbl[0]  = '{3'b100, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{3'b100, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{3'b100, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[3]  = '{3'b100, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[4]  = '{3'b100, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[5]  = '{3'b100, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1};
    tbl[6]  = '{3'b100, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[7]  = '{3'b100, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[8]  = '{3'b100, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[9]  = '{3'b101, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[10] = '{3'b101, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[11] = '{3'b101, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[12] = '{3'b101, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1};
    tbl[13] = '{3'b101, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1};
    tbl[14] = '{3'b101, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0};
    tbl[15] = '{3'b010, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0};
    tbl[16] = '{3'b010, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0};
    tbl[17] = '{3'b010, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0};
    tbl[18] = '{3'b010, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1};
    tbl[19] = '{3'b010, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1};
    tbl[20] = '{3'b010, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[21] = '{3'b001, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0};

    // Reset held through frame pulses with a volume request pending.
    for (int i = 0; i < 5; i++) cyc(3'b100, 1'b0, 1'b1);
    cyc(3'b100, 1'b0, 1'b0);
    check_all("reset", 2'd0, 1'b0, 16'h0, 16'h0, 4'hF, 8'hFF);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].req, tbl[i].frz, tbl[i].fb);
      expect_mode($sformatf("tbl%0d", i), tbl[i].cur, tbl[i].sw, tbl[i].blank);
    end

    // Freeze holds WAVE against a game request; release completes 3+2.
    for (int i = 0; i < 10; i++) begin cyc(3'b001, 1'b1, 1'b1); expect_mode("frz_hold", 2'd2, 1'b0, 1'b0); end
    cyc(3'b001, 1'b0, 1'b0); expect_mode("frz_rel", 2'd2, 1'b1, 1'b0);
    cyc(3'b001, 1'b0, 1'b1); expect_mode("frz_p1", 2'd2, 1'b1, 1'b0);
    cyc(3'b001, 1'b0, 1'b1); expect_mode("frz_p2", 2'd2, 1'b1, 1'b0);
    cyc(3'b001, 1'b0, 1'b1); expect_mode("frz_b1", 2'd2, 1'b1, 1'b1);
    cyc(3'b001, 1'b0, 1'b1); expect_mode("frz_b2", 2'd2, 1'b1, 1'b1);
    cyc(3'b001, 1'b0, 1'b1); expect_mode("frz_done", 2'd3, 1'b0, 1'b0);

    // To VOL, then a cancelled request to WAVE that never blanks.
    cyc(3'b100, 1'b0, 1'b0); expect_mode("v_p0", 2'd3, 1'b1, 1'b0);
    cyc(3'b100, 1'b0, 1'b1); expect_mode("v_p1", 2'd3, 1'b1, 1'b0);
    cyc(3'b100, 1'b0, 1'b1); expect_mode("v_p2", 2'd3, 1'b1, 1'b0);
    cyc(3'b100, 1'b0, 1'b1); expect_mode("v_b1", 2'd3, 1'b1, 1'b1);
    cyc(3'b100, 1'b0, 1'b1); expect_mode("v_b2", 2'd3, 1'b1, 1'b1);
    cyc(3'b100, 1'b0, 1'b1); expect_mode("v_done", 2'd1, 1'b0, 1'b0);
    cyc(3'b010, 1'b0, 1'b0); expect_mode("cx_p0", 2'd1, 1'b1, 1'b0);
    cyc(3'b010, 1'b0, 1'b1); expect_mode("cx_p1", 2'd1, 1'b1, 1'b0);
    cyc(3'b010, 1'b0, 1'b1); expect_mode("cx_p2", 2'd1, 1'b1, 1'b0);
    cyc(3'b100, 1'b0, 1'b1); expect_mode("cx_back", 2'd1, 1'b0, 1'b0);
    cyc(3'b100, 1'b0, 1'b1); expect_mode("cx_stay", 2'd1, 1'b0, 1'b0);

    // Blank toward WAVE, retarget to GAME mid-blank: two more blank frames.
    cyc(3'b010, 1'b0, 1'b0); expect_mode("rs_p0", 2'd1, 1'b1, 1'b0);
    cyc(3'b010, 1'b0, 1'b1); expect_mode("rs_p1", 2'd1, 1'b1, 1'b0);
    cyc(3'b010, 1'b0, 1'b1); expect_mode("rs_p2", 2'd1, 1'b1, 1'b0);
    cyc(3'b010, 1'b0, 1'b1); expect_mode("rs_b1", 2'd1, 1'b1, 1'b1);
    cyc(3'b010, 1'b0, 1'b1); expect_mode("rs_b2", 2'd1, 1'b1, 1'b1);
    cyc(3'b001, 1'b0, 1'b1); expect_mode("rs_re", 2'd1, 1'b1, 1'b1);
    cyc(3'b001, 1'b0, 1'b1); expect_mode("rs_b3", 2'd1, 1'b1, 1'b1);
    cyc(3'b001, 1'b0, 1'b1); expect_mode("rs_done", 2'd3, 1'b0, 1'b0);

    // Reset mid-BLANK and mid-PEND.
    cyc(3'b100, 1'b0, 1'b0); cyc(3'b100, 1'b0, 1'b1); cyc(3'b100, 1'b0, 1'b1);
    cyc(3'b100, 1'b0, 1'b1); expect_mode("rb_blank", 2'd3, 1'b1, 1'b1);
    reset = 1'b1; cyc(3'b100, 1'b0, 1'b0);
    check_all("rst_blank", 2'd0, 1'b0, 16'h0, 16'h0, 4'hF, 8'hFF);
    reset = 1'b0;
    cyc(3'b100, 1'b0, 1'b0); expect_mode("rp_p0", 2'd0, 1'b1, 1'b0);
    cyc(3'b100, 1'b0, 1'b1); expect_mode("rp_p1", 2'd0, 1'b1, 1'b0);
    reset = 1'b1; cyc(3'b100, 1'b0, 1'b1);
    check_all("rst_pend", 2'd0, 1'b0, 16'h0, 16'h0, 4'hF, 8'hFF);
    reset = 1'b0;

`ifdef MODE_TAG_EN
    cyc(3'b001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(3'b001, 1'b0, 1'b1);
    expect_mode("tag_game", 2'd3, 1'b0, 1'b0);
    pixel_index = 13'd95;  cyc(3'b001, 1'b0, 1'b0); chk("tag_px95",  oled_data, 16'hF800);
    pixel_index = 13'd91;  cyc(3'b001, 1'b0, 1'b0); chk("tag_px91",  oled_data, OG);
    pixel_index = 13'd479; cyc(3'b001, 1'b0, 1'b0); chk("tag_px479", oled_data, OG);
    pixel_index = 13'd380; cyc(3'b001, 1'b0, 1'b0); chk("tag_px380", oled_data, 16'hF800);
    pixel_index = '0;
`endif

    // Randomized run against the reference model.
    for (int i = 0; i < 4000; i++) begin
      reset = (i == 0) || ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) mode_req = 3'($urandom);
      if ($urandom_range(0, 19) == 0) freeze = ~freeze;
      frame_begin = ($urandom_range(0, 2) == 0);
      pixel_index = 13'($urandom_range(0, 6143));
      oled_volume = 16'($urandom); oled_wave = 16'($urandom); oled_game = 16'($urandom);
      led_mic = 16'($urandom); led_game = 16'($urandom);
      an_mic = 4'($urandom); an_game = 4'($urandom);
      seg_mic = 8'($urandom); seg_game = 8'($urandom);
      @(posedge clk);
      #1;
      model_cycle_and_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
